// File: rtl/operand_fetch.sv
// Operand feeder for the approximate-multiplier stage.
// Streams A/B pairs from a sync-read memory onto a valid/ready port.
module operand_fetch #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int NUM_PAIRS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] opA,
  output logic [DATA_W-1:0] opB,
  output logic              op_valid,
  input  logic              op_ready,
  output logic              op_last,
  output logic              busy,
  output logic              done
);

  localparam int PW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam logic [PW-1:0] PLAST = PW'(NUM_PAIRS - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    WAIT_B,
    PRESENT,
    FIN
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [PW-1:0]     p;
  logic [ADDR_W-1:0] base;
  logic              at_last;

  assign base    = ADDR_W'({p, 1'b0});
  assign at_last = (p == PLAST);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      p     <= '0;
      opA   <= '0;
      opB   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        p <= '0;
      end
      if (state == PRESENT && op_ready && !at_last) begin
        p <= p + 1'b1;
      end
      // read data lags its strobe by one cycle
      if (state == RD_B) begin
        opA <= mem_rdata;
      end
      if (state == WAIT_B) begin
        opB <= mem_rdata;
      end
    end
  end

  always_comb begin
    state_n  = state;
    mem_rd   = 1'b0;
    mem_addr = '0;
    op_valid = 1'b0;
    op_last  = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = RD_A;
        end
      end
      RD_A: begin
        mem_rd   = 1'b1;
        mem_addr = base;
        state_n  = RD_B;
      end
      RD_B: begin
        mem_rd   = 1'b1;
        mem_addr = base | ADDR_W'(1);
        state_n  = WAIT_B;
      end
      WAIT_B: begin
        state_n = PRESENT;
      end
      PRESENT: begin
        op_valid = 1'b1;
        op_last  = at_last;
        if (op_ready) begin
          state_n = at_last ? FIN : RD_A;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: reset/handshake vectors,
// directed multi-cycle runs and a randomized soak.
module tb_operand_fetch;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NP = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          op_ready = 1'b0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] opA;
  logic [DW-1:0] opB;
  logic          op_valid;
  logic          op_last;
  logic          busy;
  logic          done;

  operand_fetch #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .NUM_PAIRS(NP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .opA(opA),
    .opB(opB),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op_last(op_last),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [2**AW];

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } pair_t;

  typedef struct {
    bit            r;
    bit            s;
    bit            rd;
    bit            e_rd;
    logic [AW-1:0] e_addr;
    bit            e_v;
    bit            e_busy;
    bit            e_done;
    logic [DW-1:0] e_a;
    logic [DW-1:0] e_b;
  } vec_t;

  int    n_chk = 0;
  int    n_pass = 0;
  pair_t q[$];
  bit    run_on = 0;
  bit    exp_done = 0;
  int    age = -100;
  int    exp_addr = 0;
  int    accepts = 0;
  vec_t  tbl[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  task automatic set_pattern();
    for (int i = 0; i < NP; i++) begin
      mem[2*i]   = 16'(16'h1000 + i);
      mem[2*i+1] = 16'(16'h2000 + i);
    end
  endtask

  // One clock: drive inputs, advance, then check against the pair
  // scoreboard and the timing rules (3-cycle fetch, one done pulse).
  task automatic step(input bit r, input bit s, input bit rd);
    logic [DW-1:0] pa;
    logic [DW-1:0] pb;
    bit            pl;
    bit            mv;
    bit            was_fin;
    pa = opA;
    pb = opB;
    pl = op_last;
    mv = (age >= 3);
    rst = r;
    start = s;
    op_ready = rd;
    @(posedge clk);
    #1;
    if (r) begin
      run_on = 0;
      age = -100;
      q.delete();
      exp_done = 0;
      exp_addr = 0;
    end else begin
      was_fin = exp_done;
      exp_done = 0;
      if (was_fin) begin
        run_on = 0;
      end else if (!run_on) begin
        if (s) begin
          run_on = 1;
          age = 0;
          exp_addr = 0;
          for (int i = 0; i < NP; i++)
            q.push_back('{mem[2*i], mem[2*i+1]});
        end
      end else begin
        if (age >= 0) age++;
        if (mv && rd) begin
          accepts++;
          chk("pair_a", 32'(pa), 32'(q[0].a));
          chk("pair_b", 32'(pb), 32'(q[0].b));
          chk("pair_last", 32'(pl), 32'(q.size() == 1));
          void'(q.pop_front());
          if (q.size() == 0) begin
            exp_done = 1;
            age = -100;
          end else begin
            age = 0;
          end
        end
      end
    end
    chk("busy", 32'(busy), 32'(run_on));
    chk("op_valid", 32'(op_valid), 32'(age >= 3));
    chk("done", 32'(done), 32'(exp_done));
    chk("mem_rd", 32'(mem_rd), 32'(age == 0 || age == 1));
    if (age == 0 || age == 1) begin
      chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
      exp_addr++;
    end else begin
      chk("mem_addr_idle", 32'(mem_addr), 0);
    end
    chk("op_last", 32'(op_last), 32'(age >= 3 && q.size() == 1));
    if (!r && mv && !rd) begin
      chk("stall_a", 32'(opA), 32'(pa));
      chk("stall_b", 32'(opB), 32'(pb));
    end
    if (r) begin
      chk("rst_a", 32'(opA), 0);
      chk("rst_b", 32'(opB), 0);
    end
  endtask

  task automatic run_pairs(input int stall_pair, input int stall_len,
                           input int abort_pair, input bit poke);
    int n;
    int acc0;
    int stl;
    int pi;
    bit rdy;
    bit fin_seen;
    acc0 = accepts;
    stl = 0;
    fin_seen = 0;
    step(0, 1, 1);
    n = 1;
    while (n < 600 && !fin_seen) begin
      pi = NP - q.size();
      if (abort_pair >= 0 && op_valid && pi == abort_pair) begin
        step(1, 0, 1);
        chk("abort_valid", 32'(op_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        return;
      end
      rdy = 1;
      if (op_valid && pi == stall_pair && stl < stall_len) begin
        rdy = 0;
        stl++;
        chk("stall_pattern_a", 32'(opA), 32'(mem[2*stall_pair]));
        chk("stall_pattern_b", 32'(opB), 32'(mem[2*stall_pair+1]));
      end
      step(0, poke && n == 10, rdy);
      n++;
      if (done) fin_seen = 1;
    end
    if (!fin_seen) begin
      n_chk++;
      $display("FAIL run_timeout: no done after %0d cycles", n);
      return;
    end
    if (stall_len == 0) chk("done_latency", 32'(n), 32'(4*NP + 1));
    chk("pair_count", 32'(accepts - acc0), NP);
    step(0, poke, 0);
  endtask

  initial begin
    tbl[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 1, 0, 0, 1, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 1, 0, 1, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 1, 0, 'h1000, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 1, 1, 0, 'h1000, 'h2000};
    tbl[8]  = '{0, 0, 0, 0, 0, 1, 1, 0, 'h1000, 'h2000};
    tbl[9]  = '{0, 0, 1, 1, 2, 0, 1, 0, 'h1000, 'h2000};
    tbl[10] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    set_pattern();

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].rd);
      chk("v_rd", 32'(mem_rd), 32'(tbl[i].e_rd));
      chk("v_addr", 32'(mem_addr), 32'(tbl[i].e_addr));
      chk("v_valid", 32'(op_valid), 32'(tbl[i].e_v));
      chk("v_busy", 32'(busy), 32'(tbl[i].e_busy));
      chk("v_done", 32'(done), 32'(tbl[i].e_done));
      chk("v_opA", 32'(opA), 32'(tbl[i].e_a));
      chk("v_opB", 32'(opB), 32'(tbl[i].e_b));
    end

    run_pairs(-1, 0, -1, 0);
    step(0, 0, 0);
    run_pairs(3, 5, -1, 0);
    step(0, 0, 0);
    run_pairs(-1, 0, -1, 1);
    step(0, 0, 0);
    run_pairs(-1, 0, 2, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    run_pairs(-1, 0, -1, 0);
    run_pairs(-1, 0, -1, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0);

    for (int c = 0; c < 1500; c++) begin
      if (!run_on) mem[$urandom_range(2**AW - 1)] = DW'($urandom);
      step($urandom_range(199) == 0, $urandom_range(9) == 0,
           $urandom_range(99) < 60);
    end
    step(1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
